i2c_bus_controller: RTL and testbench

Bus-side protocol front end of the I2C subordinate. It sits directly upstream of the memory interface. It samples raw SCL/SDA on the system clock, detects START/STOP, and counts bit positions. It matches the 7-bit subordinate address and sequences the address, data and ACK phases. Its outputs are the transaction state, the bit index, the direction bits, the SDA drive enable and the master-NACK flag, which the memory interface and the top-level SDA mux consume.

---
 rtl/i2c_bus_controller.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_bus_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_controller.sv
// I2C subordinate bus front end: SCL/SDA sync, START/STOP detect, address match and phase sequencing.
// Optional `I2C_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronisers.
module i2c_bus_controller #(
    parameter logic [6:0] SUB_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic [6:0] i2c_state,
    output logic [3:0] clock_count,
    output logic       read_bit,
    output logic       write_bit,
    output logic       sda_en,
    output logic       received_nack,
    output logic       start_det,
    output logic       stop_det
);
    typedef enum logic [6:0] {
        IDLE     = 7'b0000001,
        ADDR     = 7'b0000010,
        ADDR_ACK = 7'b0000100,
        WDATA    = 7'b0001000,
        WACK     = 7'b0010000,
        RDATA    = 7'b0100000,
        RACK     = 7'b1000000
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic w_scl_s, w_sda_s;
    logic r_scl_q, r_sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] r_scl_h, r_sda_h;
    logic       r_scl_f, r_sda_f;
    logic       w_scl_y, w_sda_y;

    assign w_scl_y = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_y = r_sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_h <= 2'b11;
            r_sda_h <= 2'b11;
            r_scl_f <= 1'b1;
            r_sda_f <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[0], w_scl_y};
            r_sda_h <= {r_sda_h[0], w_sda_y};
            r_scl_f <= (w_scl_y & r_scl_h[0]) | (w_scl_y & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[1]);
            r_sda_f <= (w_sda_y & r_sda_h[0]) | (w_sda_y & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[1]);
        end
    end

    assign w_scl_s = r_scl_f;
    assign w_sda_s = r_sda_f;
`else
    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_q <= 1'b1;
            r_sda_q <= 1'b1;
        end else begin
            r_scl_q <= w_scl_s;
            r_sda_q <= w_sda_s;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl_s & ~r_scl_q;
    assign w_scl_fall = ~w_scl_s & r_scl_q;
    assign w_start    = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;

    state_t     r_state, w_state_nx;
    logic [3:0] r_count, w_count_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic       r_rd, w_rd_nx, r_wr, w_wr_nx;
    logic       r_en, w_en_nx, r_nack, w_nack_nx;
    logic       r_start, w_start_nx, r_stop, w_stop_nx;
    // The SCL fall that follows START is not a bit boundary; count only after a rise.
    logic       r_armed, w_armed_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_shift <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_en    <= 1'b0;
            r_nack  <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_shift <= w_shift_nx;
            r_rd    <= w_rd_nx;
            r_wr    <= w_wr_nx;
            r_en    <= w_en_nx;
            r_nack  <= w_nack_nx;
            r_start <= w_start_nx;
            r_stop  <= w_stop_nx;
            r_armed <= w_armed_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_shift_nx = r_shift;
        w_rd_nx    = r_rd;
        w_wr_nx    = r_wr;
        w_en_nx    = r_en;
        w_nack_nx  = r_nack;
        w_start_nx = 1'b0;
        w_stop_nx  = 1'b0;
        w_armed_nx = r_armed;
        if (w_stop || w_start) begin
            w_state_nx = w_stop ? IDLE : ADDR;
            w_count_nx = '0;
            w_rd_nx    = 1'b0;
            w_wr_nx    = 1'b0;
            w_en_nx    = 1'b0;
            w_nack_nx  = 1'b0;
            w_armed_nx = 1'b0;
            w_stop_nx  = w_stop;
            w_start_nx = ~w_stop;
        end else if (r_state != IDLE) begin
            if (w_scl_rise) begin
                w_armed_nx = 1'b1;
                if (r_state == ADDR) w_shift_nx = {r_shift[6:0], w_sda_s};
                if (r_state == RACK && w_sda_s) w_nack_nx = 1'b1;
            end
            if (w_scl_fall && r_armed) begin
                w_count_nx = (r_count == 4'd8) ? 4'd0 : r_count + 4'd1;
                unique case (r_state)
                    ADDR: if (r_count == 4'd7) begin
                        if (r_shift[7:1] == SUB_ADDR) begin
                            w_state_nx = ADDR_ACK;
                            w_en_nx    = 1'b1;
                            w_rd_nx    = r_shift[0];
                            w_wr_nx    = ~r_shift[0];
                        end else begin
                            w_state_nx = IDLE;
                            w_en_nx    = 1'b0;
                            w_count_nx = '0;
                        end
                    end
                    ADDR_ACK: if (r_count == 4'd8) begin
                        w_state_nx = r_rd ? RDATA : WDATA;
                        w_en_nx    = r_rd;
                    end
                    WDATA: if (r_count == 4'd7) begin
                        w_state_nx = WACK;
                        w_en_nx    = 1'b1;
                    end
                    WACK: if (r_count == 4'd8) begin
                        w_state_nx = WDATA;
                        w_en_nx    = 1'b0;
                    end
                    RDATA: if (r_count == 4'd7) begin
                        w_state_nx = RACK;
                        w_en_nx    = 1'b0;
                    end
                    RACK: if (r_count == 4'd8) begin
                        w_state_nx = r_nack ? IDLE : RDATA;
                        w_en_nx    = ~r_nack;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_state     = r_state;
    assign clock_count   = r_count;
    assign read_bit      = r_rd;
    assign write_bit     = r_wr;
    assign sda_en        = r_en;
    assign received_nack = r_nack;
    assign start_det     = r_start;
    assign stop_det      = r_stop;
endmodule

// File: tb/tb_i2c_bus_controller.sv
// Bench for i2c_bus_controller: directed and randomized I2C transactions against a byte-level model.
// Glitch expectations follow `I2C_GLITCH_FILTER_EN.
module tb_i2c_bus_controller;
    localparam logic [6:0] SUB  = 7'h42;
    localparam logic [6:0] IDLE = 7'h01, ADDR = 7'h02, AACK = 7'h04;
    localparam logic [6:0] WDAT = 7'h08, WACK = 7'h10, RDAT = 7'h20, RACK = 7'h40;

    logic clk, rst_n, scl, sda;
    logic [6:0] state;
    logic [3:0] cnt;
    logic rb, wb, en, nack, sdet, pdet;

    i2c_bus_controller #(.SUB_ADDR(SUB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda),
        .i2c_state(state), .clock_count(cnt), .read_bit(rb), .write_bit(wb),
        .sda_en(en), .received_nack(nack), .start_det(sdet), .stop_det(pdet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, n_start = 0, n_stop = 0;

    always @(posedge clk) begin
        if (sdet) n_start++;
        if (pdet) n_stop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        #100;
    endtask

    task automatic do_start();
        int s0;
        s0 = n_start;
        sda = 1'b1; wq();
        scl = 1'b1; wq();
        sda = 1'b0; wq();
        chk("start_pulse", n_start - s0, 1);
        chk("start_state", state, ADDR);
        chk("start_cnt", cnt, 0);
        chk("start_rw", {rb, wb}, 0);
        scl = 1'b0; wq();
    endtask

    task automatic do_stop();
        int p0;
        sda = 1'b0; wq();
        scl = 1'b1; wq();
        p0 = n_stop;
        sda = 1'b1; wq();
        chk("stop_pulse", n_stop - p0, 1);
        chk("stop_state", state, IDLE);
        chk("stop_cnt", cnt, 0);
        chk("stop_flags", {rb, wb, en, nack}, 0);
    endtask

    task automatic bit_cyc(input logic b, input logic [6:0] es, input logic [3:0] ec,
                           input logic een, input string tag);
        sda = b; wq();
        scl = 1'b1; wq();
        chk({tag, "_state"}, state, es);
        chk({tag, "_cnt"}, cnt, ec);
        chk({tag, "_en"}, en, een);
        wq();
        scl = 1'b0; wq();
    endtask

    // Byte-level reference: expectations follow from address match, R/W and the ACK of each byte.
    task automatic xfer(input logic [6:0] a, input logic rw, input int nbytes,
                        input logic nack_last, input logic [7:0] d0, input logic [7:0] d1);
        logic match, nk;
        logic [7:0] ab, d;
        logic [6:0] ds;
        match = (a == SUB);
        ab = {a, rw};
        do_start();
        for (int i = 0; i < 8; i++)
            bit_cyc(ab[7-i], ADDR, 4'(i), 1'b0, $sformatf("addr%0d", i));
        if (match) begin
            bit_cyc(1'b0, AACK, 4'd8, 1'b1, "aack");
            chk("rw_bits", {rb, wb}, {rw, ~rw});
        end else begin
            bit_cyc(1'b1, IDLE, 4'd0, 1'b0, "anack");
        end
        ds = !match ? IDLE : (rw ? RDAT : WDAT);
        for (int j = 0; j < nbytes; j++) begin
            d = (j == 0) ? d0 : (j == 1) ? d1 : 8'($urandom);
            for (int k = 0; k < 8; k++)
                bit_cyc(d[7-k], ds, match ? 4'(k) : 4'd0, match && rw, $sformatf("data%0d_%0d", j, k));
            if (!match) begin
                bit_cyc(1'b1, IDLE, 4'd0, 1'b0, "ign_ack");
            end else if (!rw) begin
                bit_cyc(1'b0, WACK, 4'd8, 1'b1, "wack");
            end else begin
                nk = nack_last && (j == nbytes - 1);
                bit_cyc(nk, RACK, 4'd8, 1'b0, "rack");
                chk("rnack", nack, nk);
            end
        end
        if (match && rw && nack_last) begin
            chk("nack_state", state, IDLE);
            chk("nack_en", en, 0);
            chk("nack_hold", nack, 1);
        end
        do_stop();
    endtask

    initial begin
        int s0, p0;
        logic [6:0] a;
        rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
        #23;
        chk("rst_state", state, IDLE);
        chk("rst_cnt", cnt, 0);
        chk("rst_flags", {rb, wb, en, nack, sdet, pdet}, 0);
        #30 rst_n = 1'b1;
        wq();

        xfer(SUB, 1'b0, 2, 1'b0, 8'hA5, 8'h3C);
        xfer(7'h43, 1'b0, 2, 1'b0, 8'h11, 8'h22);
        xfer(SUB, 1'b1, 3, 1'b1, 8'h5A, 8'hC3);

        // repeated START in the middle of a write byte
        do_start();
        for (int i = 0; i < 8; i++)
            bit_cyc(SUB[6 - (i < 7 ? i : 6)] & (i < 7), ADDR, 4'(i), 1'b0, "rs_addr");
        bit_cyc(1'b0, AACK, 4'd8, 1'b1, "rs_aack");
        for (int k = 0; k < 3; k++)
            bit_cyc(1'b1, WDAT, 4'(k), 1'b0, "rs_data");
        sda = 1'b1; wq();
        scl = 1'b1; wq();
        chk("rs_pre_cnt", cnt, 3);
        s0 = n_start;
        sda = 1'b0; wq();
        chk("rs_pulse", n_start - s0, 1);
        chk("rs_state", state, ADDR);
        chk("rs_cnt", cnt, 0);
        chk("rs_wb", wb, 0);
        scl = 1'b0; wq();
        do_stop();

        // reset in the middle of a write data byte
        do_start();
        for (int i = 0; i < 8; i++)
            bit_cyc(i < 7 ? SUB[6-i] : 1'b0, ADDR, 4'(i), 1'b0, "mr_addr");
        bit_cyc(1'b0, AACK, 4'd8, 1'b1, "mr_aack");
        bit_cyc(1'b0, WDAT, 4'd0, 1'b0, "mr_data");
        rst_n = 1'b0;
        #1;
        chk("mr_state", state, IDLE);
        chk("mr_cnt", cnt, 0);
        chk("mr_en", en, 0);
        #19 rst_n = 1'b1;
        sda = 1'b1; wq();
        scl = 1'b1; wq();
        scl = 1'b0; wq();
        bit_cyc(1'b0, IDLE, 4'd0, 1'b0, "mr_wait0");
        bit_cyc(1'b1, IDLE, 4'd0, 1'b0, "mr_wait1");
        sda = 1'b1; wq();
        scl = 1'b1; wq();

        for (int t = 0; t < 6; t++) begin
            a = ($urandom % 2) ? SUB : 7'($urandom);
            if (t == 0) a = SUB;
            if (t == 1 && a == SUB) a = SUB ^ 7'h10;
            xfer(a, 1'($urandom), 1 + int'($urandom % 3), 1'($urandom),
                 8'($urandom), 8'($urandom));
        end

        // single-clk low spike on SDA while SCL is high
        s0 = n_start;
        p0 = n_stop;
        @(negedge clk) sda = 1'b0;
        @(negedge clk) sda = 1'b1;
        repeat (12) @(negedge clk);
`ifdef I2C_GLITCH_FILTER_EN
        chk("glitch_start", n_start - s0, 0);
        chk("glitch_stop", n_stop - p0, 0);
`else
        chk("glitch_start", n_start - s0, 1);
`endif
        chk("glitch_state", state, IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
